mac_tx_frame_fifo: RTL and testbench
====================================

// Module: mac_tx_frame_fifo
// PURPOSE
//  Parametrised store-and-forward TX FIFO between the MAC TX framer (write side) and the XGMII encoder (read side).
//  Stores one word per cycle: N_CHANNELS lanes of data, a ctrl bit per lane, and a frame-last flag.
//  Words of a frame are written speculatively and become readable only after the frame's last word commits.
//  Partial or overflowed frames are rolled back, so the PHY never sees a truncated frame.
// PARAMETERS
//  N_CHANNELS    4   byte lanes per word
//  W_BYTE        8   bits per lane
//  DEPTH         16  entries; power of two, >= 4
//  AFULL_THRESH  12  o_afull asserts when write occupancy >= this value; 1..DEPTH
// PORTS
//  i_clk       in   1                   clock
//  i_reset     in   1                   synchronous, active-high reset
//  i_clk_en    in   1                   state advances only when high
//  i_clr       in   1                   synchronous flush; qualified by i_clk_en
//  i_wen       in   1                   write strobe
//  i_wctrl     in   N_CHANNELS          per-lane ctrl bits
//  i_wdata     in   N_CHANNELS*W_BYTE   lane data; lane 0 in the LSBs
//  i_wlast     in   1                   qualifies i_wen; last word of frame, commits the frame
//  i_wabort    in   1                   discards the uncommitted frame
//  i_ren       in   1                   pop the head word
//  o_rctrl     out  N_CHANNELS          head ctrl bits; 0 when o_empty
//  o_rdata     out  N_CHANNELS*W_BYTE   head data; 0 when o_empty
//  o_rlast     out  1                   head word ends its frame; 0 when o_empty
//  o_empty     out  1                   no committed words available
//  o_full      out  1                   write occupancy == DEPTH
//  o_afull     out  1                   write occupancy >= AFULL_THRESH
//  o_rcount    out  $clog2(DEPTH)+1     committed words readable
//  o_ovf       out  1                   sticky: write attempted while full
//  o_udf       out  1                   sticky: read attempted while empty
// BEHAVIOUR
//  Pointers:
//   - Three pointers, each $clog2(DEPTH)+1 bits with a wrap bit: wptr (speculative write), cptr (committed), rptr.
//   - Write occupancy = wptr-rptr; o_rcount = cptr-rptr; o_empty = (cptr==rptr). Modulo arithmetic throughout.
//  Flags:
//   - All flags are computed from registered state.
//   - A same-cycle read does not free space for a same-cycle write; a full FIFO rejects the write.
//  Read path:
//   - First-word fall-through, zero latency: o_r* show mem[rptr] combinationally.
//   - i_ren & !o_empty -> rptr+1.
//   - i_ren & o_empty -> rptr unchanged, o_udf<=1.
//  Write path:
//   - i_wen & !o_full -> store {i_wlast, i_wctrl, i_wdata} at wptr; wptr+1.
//   - i_wen & o_full -> word dropped, o_ovf<=1, frame marked bad (internal q_bad<=1).
//  Commit (i_wen & i_wlast):
//   - Frame good and word stored -> cptr<=wptr+1.
//   - Frame bad, or the last word was dropped -> wptr<=cptr, q_bad<=0. Whole frame discarded.
//  Abort:
//   - i_wabort -> wptr<=cptr, q_bad<=0.
//   - Abort wins over a same-cycle i_wen; that word is dropped.
//  Priority: i_reset > !i_clk_en (hold all state) > i_clr > abort > write/commit. Reads are independent of writes.
//  i_clr: clears all pointers, q_bad, o_ovf and o_udf. Memory is not cleared.
//  Reset values:
//   - Pointers 0, q_bad 0, o_ovf 0, o_udf 0.
//   - Outputs: o_empty 1, o_full 0, o_afull 0, o_rcount 0; o_rdata, o_rctrl, o_rlast all 0.
//   - Memory is not reset; outputs are masked by o_empty.
//  Reset mid-frame: the uncommitted frame is lost; the write side restarts from an empty FIFO.
//  A frame longer than DEPTH can never commit; it is discarded at i_wlast via the overflow path.
// STRUCTURE
//  mac_params (shared package):
//   - N_CHANNELS and W_BYTE.
//   - MAC_TX_FIFO_DEPTH.
//   - Derived W_MAC_TX_FIFO_WORD = N_CHANNELS*W_BYTE+N_CHANNELS+1.
//   - typedef struct packed {logic last; logic [N_CHANNELS-1:0] ctrl; logic [N_CHANNELS-1:0][W_BYTE-1:0] data;} mac_tx_word_t.
//  Sub-module mac_tx_fifo_mem:
//   - DEPTH x mac_tx_word_t.
//   - One synchronous write port gated by i_clk_en; one combinational read port.
//   - No reset.
//  Top level: pointers, commit/rollback logic and flags.
// TESTING (DEPTH=8, AFULL_THRESH=6)
//  1. Write a 3-word frame (wlast on word 3).
//     -> o_empty stays 1 through word 2; the cycle after word 3, o_empty=0 and o_rcount=3.
//     -> 3 reads return the words in order, with o_rlast only on word 3.
//  2. Write 2 words, then i_wabort.
//     -> o_rcount stays 0; the next 3-word frame reads back intact with no stale words.
//  3. Write a 10-word frame with no reads.
//     -> o_full after word 8; o_ovf=1 on word 9.
//     -> At wlast the frame is discarded: o_rcount=0, write occupancy 0, o_ovf stays 1.
//  4. Commit a 5-word frame, then read and write simultaneously every cycle across the wrap.
//     -> Data is in order, o_rcount is steady, o_afull asserts exactly at occupancy 6.
//  5. i_ren while empty -> o_udf=1 and rptr unchanged. i_clr -> o_udf=0, o_ovf=0, o_empty=1.
//  6. Hold i_clk_en=0 while toggling i_wen/i_ren/i_clr -> no state change. Assert i_reset mid-frame -> all reset values.

Source files
------------

// File: rtl/mac_tx_frame_fifo_pkg.sv
// Shared MAC TX parameters and the FIFO word layout.
// Lane 0 sits in the LSBs of data; last is the MSB of the word.
package mac_params;
  localparam int N_CHANNELS         = 4;
  localparam int W_BYTE             = 8;
  localparam int MAC_TX_FIFO_DEPTH  = 16;
  localparam int W_MAC_TX_FIFO_WORD = N_CHANNELS*W_BYTE + N_CHANNELS + 1;

  typedef struct packed {
    logic                                 last;
    logic [N_CHANNELS-1:0]                ctrl;
    logic [N_CHANNELS-1:0][W_BYTE-1:0]    data;
  } mac_tx_word_t;
endpackage

// File: rtl/mac_tx_frame_fifo_if.sv
// Framer-side write bus and encoder-side read bus of the TX frame FIFO.
// master drives writes/reads, slave is the FIFO.
interface mac_tx_frame_fifo_if #(parameter int DEPTH = 16);
  import mac_params::*;
  localparam int PW = $clog2(DEPTH) + 1;

  logic                         i_wen;
  logic [N_CHANNELS-1:0]        i_wctrl;
  logic [N_CHANNELS*W_BYTE-1:0] i_wdata;
  logic                         i_wlast;
  logic                         i_wabort;
  logic                         i_ren;
  logic [N_CHANNELS-1:0]        o_rctrl;
  logic [N_CHANNELS*W_BYTE-1:0] o_rdata;
  logic                         o_rlast;
  logic                         o_empty;
  logic                         o_full;
  logic                         o_afull;
  logic [PW-1:0]                o_rcount;
  logic                         o_ovf;
  logic                         o_udf;

  modport master (
    output i_wen, i_wctrl, i_wdata, i_wlast, i_wabort, i_ren,
    input  o_rctrl, o_rdata, o_rlast, o_empty, o_full, o_afull, o_rcount, o_ovf, o_udf
  );
  modport slave (
    input  i_wen, i_wctrl, i_wdata, i_wlast, i_wabort, i_ren,
    output o_rctrl, o_rdata, o_rlast, o_empty, o_full, o_afull, o_rcount, o_ovf, o_udf
  );
endinterface

// File: rtl/mac_tx_fifo_mem.sv
// FIFO storage: one clock-enabled synchronous write port, one combinational read port.
// No reset; the top masks the read data while the FIFO is empty.
module mac_tx_fifo_mem
  import mac_params::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_clk_en,
  input  logic         i_we,
  input  logic [AW-1:0] i_waddr,
  input  mac_tx_word_t i_wword,
  input  logic [AW-1:0] i_raddr,
  output mac_tx_word_t o_rword
);
  mac_tx_word_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clk_en && i_we) mem[i_waddr] <= i_wword;
  end

  assign o_rword = mem[i_raddr];
endmodule

// File: rtl/mac_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: words are written speculatively at wptr and
// become visible to the reader only when the frame's last word moves cptr.
module mac_tx_frame_fifo
  import mac_params::*;
#(
  parameter int DEPTH        = MAC_TX_FIFO_DEPTH,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 i_clr,
  mac_tx_frame_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr, cptr, rptr;
  logic          q_bad, ovf, udf;
  logic [PW-1:0] occ;
  logic          empty, full, mem_we;
  mac_tx_word_t  wword, rword;

  assign occ   = wptr - rptr;
  assign empty = (cptr == rptr);
  assign full  = (occ == PW'(DEPTH));

  assign wword  = {bus.i_wlast, bus.i_wctrl, bus.i_wdata};
  // Same gating as the wptr advance below, so memory and pointer never diverge.
  assign mem_we = !i_reset && !i_clr && !bus.i_wabort && bus.i_wen && !full;

  mac_tx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk    (i_clk),
    .i_clk_en (i_clk_en),
    .i_we     (mem_we),
    .i_waddr  (wptr[AW-1:0]),
    .i_wword  (wword),
    .i_raddr  (rptr[AW-1:0]),
    .o_rword  (rword)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr <= '0; cptr <= '0; rptr <= '0;
      q_bad <= 1'b0; ovf <= 1'b0; udf <= 1'b0;
    end else if (i_clk_en) begin
      if (i_clr) begin
        wptr <= '0; cptr <= '0; rptr <= '0;
        q_bad <= 1'b0; ovf <= 1'b0; udf <= 1'b0;
      end else begin
        if (bus.i_ren) begin
          if (!empty) rptr <= rptr + 1'b1;
          else        udf  <= 1'b1;
        end
        if (bus.i_wabort) begin
          wptr  <= cptr;
          q_bad <= 1'b0;
        end else if (bus.i_wen) begin
          if (full) begin
            ovf <= 1'b1;
            // A dropped last word means the frame can never be whole: discard it.
            if (bus.i_wlast) begin
              wptr  <= cptr;
              q_bad <= 1'b0;
            end else begin
              q_bad <= 1'b1;
            end
          end else if (bus.i_wlast) begin
            if (q_bad) begin
              wptr  <= cptr;
              q_bad <= 1'b0;
            end else begin
              wptr <= wptr + 1'b1;
              cptr <= wptr + 1'b1;
            end
          end else begin
            wptr <= wptr + 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_empty  = empty;
  assign bus.o_full   = full;
  assign bus.o_afull  = (occ >= PW'(AFULL_THRESH));
  assign bus.o_rcount = cptr - rptr;
  assign bus.o_ovf    = ovf;
  assign bus.o_udf    = udf;
  assign bus.o_rdata  = empty ? '0 : rword.data;
  assign bus.o_rctrl  = empty ? '0 : rword.ctrl;
  assign bus.o_rlast  = empty ? 1'b0 : rword.last;
endmodule

// File: tb/tb_mac_tx_frame_fifo.sv
// Directed bench for mac_tx_frame_fifo at DEPTH=8, AFULL_THRESH=6.
module tb_mac_tx_frame_fifo;
  import mac_params::*;
  localparam int DEPTH = 8;

  logic i_clk = 1'b0, i_reset = 1'b1, i_clk_en = 1'b1, i_clr = 1'b0;
  int   n_vec = 0, n_err = 0;
  mac_tx_word_t q[$];
  mac_tx_word_t w;

  mac_tx_frame_fifo_if #(.DEPTH(DEPTH)) bus ();

  mac_tx_frame_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(6)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .i_clr    (i_clr),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic mac_tx_word_t mk(input int n, input logic last);
    mac_tx_word_t r;
    r.data = 32'h01010101 * n + 32'h00102030;
    r.ctrl = 4'(n);
    r.last = last;
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wen = 0; bus.i_wlast = 0; bus.i_wabort = 0; bus.i_ren = 0;
    bus.i_wdata = '0; bus.i_wctrl = '0;
  endtask

  task automatic drive_w(input mac_tx_word_t x);
    bus.i_wen = 1; bus.i_wlast = x.last; bus.i_wctrl = x.ctrl; bus.i_wdata = x.data;
  endtask

  task automatic wr(input mac_tx_word_t x);
    drive_w(x);
    tick();
    idle();
  endtask

  task automatic rd_chk(input string tag, input mac_tx_word_t x);
    chk({tag, ".data"}, 64'(bus.o_rdata), 64'(x.data));
    chk({tag, ".ctrl"}, 64'(bus.o_rctrl), 64'(x.ctrl));
    chk({tag, ".last"}, 64'(bus.o_rlast), 64'(x.last));
    bus.i_ren = 1;
    tick();
    bus.i_ren = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".empty"},  64'(bus.o_empty),  64'd1);
    chk({tag, ".full"},   64'(bus.o_full),   64'd0);
    chk({tag, ".afull"},  64'(bus.o_afull),  64'd0);
    chk({tag, ".rcount"}, 64'(bus.o_rcount), 64'd0);
    chk({tag, ".rdata"},  64'(bus.o_rdata),  64'd0);
    chk({tag, ".rctrl"},  64'(bus.o_rctrl),  64'd0);
    chk({tag, ".rlast"},  64'(bus.o_rlast),  64'd0);
    chk({tag, ".ovf"},    64'(bus.o_ovf),    64'd0);
    chk({tag, ".udf"},    64'(bus.o_udf),    64'd0);
  endtask

  initial begin
    idle();
    tick(); tick();
    i_reset = 0;
    chk_reset_vals("rst");

    // 1: 3-word frame, visible only after the last word
    wr(mk(1, 0)); chk("t1.empty_w1", 64'(bus.o_empty), 64'd1);
    wr(mk(2, 0)); chk("t1.empty_w2", 64'(bus.o_empty), 64'd1);
    wr(mk(3, 1));
    chk("t1.empty_w3", 64'(bus.o_empty), 64'd0);
    chk("t1.rcount",   64'(bus.o_rcount), 64'd3);
    rd_chk("t1.r1", mk(1, 0));
    rd_chk("t1.r2", mk(2, 0));
    rd_chk("t1.r3", mk(3, 1));
    chk("t1.empty_end", 64'(bus.o_empty), 64'd1);

    // 2: abort discards the partial frame
    wr(mk(11, 0)); wr(mk(12, 0));
    bus.i_wabort = 1; tick(); idle();
    chk("t2.rcount", 64'(bus.o_rcount), 64'd0);
    chk("t2.afull",  64'(bus.o_afull),  64'd0);
    wr(mk(21, 0)); wr(mk(22, 0)); wr(mk(23, 1));
    chk("t2.rcount3", 64'(bus.o_rcount), 64'd3);
    rd_chk("t2.r1", mk(21, 0));
    rd_chk("t2.r2", mk(22, 0));
    rd_chk("t2.r3", mk(23, 1));

    // 3: oversize frame overflows and is discarded at wlast
    for (int i = 1; i <= 8; i++) begin
      wr(mk(30 + i, 0));
      if (i == 5) chk("t3.afull5", 64'(bus.o_afull), 64'd0);
      if (i == 6) chk("t3.afull6", 64'(bus.o_afull), 64'd1);
      if (i == 7) chk("t3.full7",  64'(bus.o_full),  64'd0);
    end
    chk("t3.full8", 64'(bus.o_full), 64'd1);
    chk("t3.ovf8",  64'(bus.o_ovf),  64'd0);
    chk("t3.empty8", 64'(bus.o_empty), 64'd1);
    wr(mk(39, 0));
    chk("t3.ovf9", 64'(bus.o_ovf), 64'd1);
    wr(mk(40, 1));
    chk("t3.rcount", 64'(bus.o_rcount), 64'd0);
    chk("t3.full",   64'(bus.o_full),   64'd0);
    chk("t3.afull",  64'(bus.o_afull),  64'd0);
    chk("t3.ovf",    64'(bus.o_ovf),    64'd1);

    // 4: 5-word frame, then concurrent 1-word-frame writes and reads across the wrap
    for (int i = 0; i < 5; i++) begin
      w = mk(41 + i, i == 4);
      wr(w);
      q.push_back(w);
    end
    chk("t4.rcount5", 64'(bus.o_rcount), 64'd5);
    chk("t4.afull5",  64'(bus.o_afull),  64'd0);
    for (int i = 0; i < 8; i++) begin
      w = mk(60 + i, 1);
      chk("t4.rw.data", 64'(bus.o_rdata), 64'(q[0].data));
      chk("t4.rw.last", 64'(bus.o_rlast), 64'(q[0].last));
      drive_w(w); bus.i_ren = 1;
      tick(); idle();
      void'(q.pop_front());
      q.push_back(w);
      chk("t4.rw.rcount", 64'(bus.o_rcount), 64'd5);
      chk("t4.rw.afull",  64'(bus.o_afull),  64'd0);
    end
    w = mk(70, 1);
    wr(w); q.push_back(w);
    chk("t4.afull6",  64'(bus.o_afull),  64'd1);
    chk("t4.rcount6", 64'(bus.o_rcount), 64'd6);
    chk("t4.full6",   64'(bus.o_full),   64'd0);
    while (q.size() > 0) begin
      rd_chk("t4.drain", q[0]);
      void'(q.pop_front());
    end
    chk("t4.empty", 64'(bus.o_empty), 64'd1);

    // 5: underflow, then clear
    bus.i_ren = 1; tick(); idle();
    chk("t5.udf",    64'(bus.o_udf),    64'd1);
    chk("t5.rcount", 64'(bus.o_rcount), 64'd0);
    wr(mk(77, 1));
    chk("t5.rcount1", 64'(bus.o_rcount), 64'd1);
    chk("t5.head",    64'(bus.o_rdata),  64'(mk(77, 1).data));
    i_clr = 1; tick(); i_clr = 0;
    chk("t5.clr.udf",   64'(bus.o_udf),   64'd0);
    chk("t5.clr.ovf",   64'(bus.o_ovf),   64'd0);
    chk("t5.clr.empty", 64'(bus.o_empty), 64'd1);

    // 6: clock enable low freezes everything; reset mid-frame
    wr(mk(88, 1));
    i_clk_en = 0;
    for (int i = 0; i < 3; i++) begin
      drive_w(mk(90 + i, i[0])); bus.i_ren = 1; i_clr = i[1]; bus.i_wabort = i[0];
      tick();
    end
    idle(); i_clr = 0; i_clk_en = 1;
    chk("t6.hold.rcount", 64'(bus.o_rcount), 64'd1);
    chk("t6.hold.data",   64'(bus.o_rdata),  64'(mk(88, 1).data));
    chk("t6.hold.udf",    64'(bus.o_udf),    64'd0);
    chk("t6.hold.afull",  64'(bus.o_afull),  64'd0);
    wr(mk(99, 0)); wr(mk(100, 0));
    i_reset = 1; tick(); i_reset = 0;
    chk_reset_vals("t6.rst");
    wr(mk(101, 1));
    rd_chk("t6.post", mk(101, 1));
    chk("t6.post.empty", 64'(bus.o_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
